// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO-side signal bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 64
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DWIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [DWIDTH-1:0]         fifo_data_o;
    logic                      fifo_wrreq_o;
    logic                      fifo_full_i;
    logic                      fifo_almost_full_i;
    logic [NUM_REQ-1:0]        grant_o;
    logic                      busy_o;

    // Arbiter side
    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  fifo_full_i,
        input  fifo_almost_full_i,
        output req_ready_o,
        output fifo_data_o,
        output fifo_wrreq_o,
        output grant_o,
        output busy_o
    );

    // Requester/FIFO environment side
    modport master (
        output req_valid_i,
        output req_data_i,
        output fifo_full_i,
        output fifo_almost_full_i,
        input  req_ready_o,
        input  fifo_data_o,
        input  fifo_wrreq_o,
        input  grant_o,
        input  busy_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter merging N requesters into one FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = 64,
    parameter int BURST_LEN = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] BURST_MAX  = CW'(BURST_LEN);
    localparam logic [OW-1:0] LAST_RESET = OW'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       w_owner_nxt;
    logic [OW-1:0]       r_last_owner;
    logic [OW-1:0]       w_last_owner_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [CW-1:0]       w_cnt_inc;

    logic                w_busy;
    logic [NUM_REQ-1:0]  w_owner_onehot;
    logic                w_owner_valid;
    logic [DWIDTH-1:0]   w_owner_data;
    logic                w_xfer;

    logic [OW-1:0]       w_rr_idx;
    logic [OW-1:0]       w_rr_pick;
    logic                w_rr_found;

    assign w_busy         = (r_state == ST_BUSY);
    assign w_owner_onehot = NUM_REQ'(1) << r_owner;
    assign w_xfer         = w_busy && !bus.fifo_full_i && w_owner_valid;
    assign w_cnt_inc      = r_cnt + 1'b1;

    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == OW'(k)) begin
                w_owner_valid = bus.req_valid_i[k];
                w_owner_data  = bus.req_data_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = r_last_owner;
        w_rr_idx   = r_last_owner;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_rr_idx = OW'((int'(r_last_owner) + i) % NUM_REQ);
            if (!w_rr_found && bus.req_valid_i[w_rr_idx]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_rr_idx;
            end
        end
    end

    // FIFO-facing outputs are combinational so a granted word reaches the FIFO in the same cycle.
    assign bus.req_ready_o  = (w_busy && !bus.fifo_full_i) ? w_owner_onehot : '0;
    assign bus.fifo_wrreq_o = w_xfer;
    assign bus.fifo_data_o  = w_busy ? w_owner_data : '0;
    assign bus.grant_o      = w_busy ? w_owner_onehot : '0;
    assign bus.busy_o       = w_busy;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found && !bus.fifo_almost_full_i) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = w_rr_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                // A dropped valid ends the burst even during a full stall.
                if (!w_owner_valid || (w_xfer && (w_cnt_inc == BURST_MAX))) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= LAST_RESET;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter DWIDTH, default 64, data word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 8, maximum words per grant (1..256).
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state updates on posedge.
REQ-005 The block SHALL have port arst_i, input, 1, reset, asynchronous and active-high.
REQ-006 The block SHALL have port req_valid_i, input, NUM_REQ, per-requester word valid.
REQ-007 The block SHALL have port req_data_i, input, NUM_REQ*DWIDTH, per-requester data; requester k occupies bits [k*DWIDTH +: DWIDTH].
REQ-008 The block SHALL have port req_ready_o, input-facing output, NUM_REQ, per-requester accept.
REQ-009 The block SHALL have port fifo_data_o, output, DWIDTH, FIFO write data.
REQ-010 The block SHALL have port fifo_wrreq_o, output, 1, FIFO write request.
REQ-011 The block SHALL have port fifo_full_i, input, 1, FIFO full flag.
REQ-012 The block SHALL have port fifo_almost_full_i, input, 1, FIFO almost-full flag.
REQ-013 The block SHALL have port grant_o, output, NUM_REQ, one-hot current owner; all zero when idle.
REQ-014 The block SHALL have port busy_o, output, 1, high while in state BUSY.

Function
REQ-015 A transfer on requester k SHALL occur in a cycle where req_valid_i[k] and req_ready_o[k] are both high.
REQ-016 Requesters SHALL hold valid and data stable until the transfer; the block does not buffer words.
REQ-017 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-018 In IDLE, when any req_valid_i bit is high and fifo_almost_full_i is low, the block SHALL select the first valid requester in round-robin order starting at last_owner+1 (mod NUM_REQ), register it as owner, and enter BUSY on the next edge.
REQ-019 In IDLE with fifo_almost_full_i high, the block SHALL issue no grant and SHALL remain in IDLE.
REQ-020 In BUSY, req_ready_o SHALL be high only for the owner and only when fifo_full_i is low; all other ready bits SHALL be 0.
REQ-021 req_ready_o, fifo_wrreq_o and fifo_data_o SHALL be combinational from registered owner/state and current inputs, with zero-cycle latency to the FIFO.
REQ-022 fifo_wrreq_o SHALL equal req_valid_i[owner] AND req_ready_o[owner]; it SHALL be 0 in IDLE.
REQ-023 fifo_data_o SHALL equal the owner's req_data_i slice in BUSY and all zeros in IDLE.
REQ-024 A burst counter of width clog2(BURST_LEN)+1 SHALL clear on entry to BUSY and increment on each owner transfer.
REQ-025 BUSY SHALL exit to IDLE after the transfer that makes the counter equal BURST_LEN.
REQ-026 BUSY SHALL exit to IDLE in any cycle where req_valid_i[owner] is low, including while fifo_full_i is high.
REQ-027 fifo_almost_full_i SHALL NOT terminate an ongoing burst; only fifo_full_i stalls it.
REQ-028 On exit from BUSY, last_owner SHALL take the owner value; exit to IDLE always costs one idle cycle before the next grant.
REQ-029 Valid changes of non-owners during BUSY SHALL have no effect until IDLE.
REQ-030 The block SHALL never assert fifo_wrreq_o while fifo_full_i is high.

Reset
REQ-031 While arst_i is high, the block SHALL force state IDLE, owner 0, last_owner NUM_REQ-1, burst counter 0, grant_o 0, busy_o 0; req_ready_o, fifo_wrreq_o and fifo_data_o SHALL therefore be 0 immediately, without a clock.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no further write; after release, the first grant SHALL go to requester 0 if it is valid.

Verification
REQ-033 Reset test: all four requesters valid at reset release -> grants go in order 0,1,2,3,0, each after a one-cycle IDLE gap.
REQ-034 Burst limit test: BURST_LEN=8, requester 2 alone, valid held for 20 words -> 8 writes, 1 idle cycle, 8 writes, 1 idle cycle, 4 writes; data order preserved.
REQ-035 Full stall test: fifo_full_i high for 3 cycles mid-burst -> fifo_wrreq_o and req_ready_o low for those 3 cycles; burst resumes; the total word count is unchanged.
REQ-036 Early release test: owner 1 drops valid after 3 words while requester 3 is valid -> BUSY exits, then requester 3 is granted after one IDLE cycle.
REQ-037 Almost-full test: fifo_almost_full_i high in IDLE with requester 0 valid -> no grant; deasserted -> grant on the next edge; almost-full during BUSY -> burst continues.
REQ-038 Async reset test: arst_i pulsed between clock edges mid-burst -> outputs go to 0 before the next edge, and no write occurs in the following cycle.
